// File: rtl/serial_pattern_tx.sv
// Serial stimulus source for the two-state sequence detector: shifts a loaded word
// out MSB-first on w and counts the "11" adjacencies it transmits.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bitcnt_q;
  logic             prev_w_q;
  logic [CNT_W-1:0] pair_cnt_q;
  logic             accept;

  // A new word is taken from IDLE or from the DONE gap cycle, never mid-word.
  assign accept = load && (state_q == IDLE || state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so every path drives state_d and no latch is inferred.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = load ? SHIFT : IDLE;
      SHIFT:   state_d = (bitcnt_q == LAST_BIT) ? DONE : SHIFT;
      DONE:    state_d = load ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT: begin
        w    = shreg_q[WIDTH-1];
        busy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // prev_w is cleared on load so the pair count never spans two words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      prev_w_q   <= 1'b0;
      pair_cnt_q <= '0;
    end else if (accept) begin
      shreg_q    <= data;
      bitcnt_q   <= '0;
      prev_w_q   <= 1'b0;
      pair_cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
      bitcnt_q <= bitcnt_q + BW'(1);
      prev_w_q <= w;
      if (w && prev_w_q) pair_cnt_q <= pair_cnt_q + CNT_W'(1);
    end
  end

  assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed and random words compared
// against a bit-queue model of the transmitted stream and its "11" pair count.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             w;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pair_cnt;

  int total = 0;
  int bad   = 0;

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .w        (w),
    .busy     (busy),
    .done     (done),
    .pair_cnt (pair_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: number of "11" adjacencies among the first n transmitted bits.
  function automatic int model_pairs(input logic [WIDTH-1:0] d, input int n);
    bit stream[$];
    int cnt = 0;
    for (int i = WIDTH - 1; i >= 0; i--) stream.push_back(d[i]);
    for (int m = 1; m < n; m++) if (stream[m] && stream[m-1]) cnt++;
    return cnt;
  endfunction

  // Loads d (from IDLE or DONE), checks every serial cycle and the done cycle.
  // glitch_at >= 0 pulses load with gdata during that shift cycle.
  task automatic send_word(input logic [WIDTH-1:0] d, input bit hold,
                           input int glitch_at, input logic [WIDTH-1:0] gdata);
    load = 1'b1;
    data = d;
    tick();
    if (!hold) begin
      load = 1'b0;
      data = WIDTH'($urandom);
    end
    for (int j = 0; j < WIDTH; j++) begin
      check("w_bit", 32'(w), 32'(d[WIDTH-1-j]));
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      check("pair_running", 32'(pair_cnt), 32'(model_pairs(d, j)));
      if (j == glitch_at) begin
        load = 1'b1;
        data = gdata;
      end else if (!hold) begin
        load = 1'b0;
        data = WIDTH'($urandom);
      end
      tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("w_gap", 32'(w), 32'd0);
    check("pair_final", 32'(pair_cnt), 32'(model_pairs(d, WIDTH)));
  endtask

  // Idle cycles with load low: outputs quiet, pair_cnt holds.
  task automatic idle(input int n, input int exp_pairs);
    load = 1'b0;
    for (int i = 0; i < n; i++) begin
      data = WIDTH'($urandom);
      tick();
      check("w_idle", 32'(w), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("done_idle", 32'(done), 32'd0);
      check("pair_hold", 32'(pair_cnt), 32'(exp_pairs));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    reset = 1'b1;
    load  = 1'b0;
    data  = '0;
    tick();
    tick();
    check("rst_w", 32'(w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pair", 32'(pair_cnt), 32'd0);
    // load high during reset must not start a word
    load = 1'b1;
    tick();
    check("rst_load_busy", 32'(busy), 32'd0);
    load  = 1'b0;
    reset = 1'b0;
    idle(2, 0);

    send_word(8'b0110_1110, 1'b0, -1, '0);
    idle(2, 3);
    send_word(8'hFF, 1'b0, -1, '0);
    idle(1, 7);
    send_word(8'h55, 1'b0, -1, '0);
    idle(1, 0);
    // second load during cycle 3 of an active word is ignored
    send_word(8'hF0, 1'b0, 2, 8'hC0);
    idle(1, 3);

    // load held high: back-to-back words with a single DONE gap each
    load = 1'b1;
    data = 8'h81;
    for (int r = 0; r < 3; r++) send_word(8'h81, 1'b1, -1, '0);
    idle(1, 0);

    // asynchronous reset mid-SHIFT aborts the word immediately
    load = 1'b1;
    data = 8'hFF;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_pair", 32'(pair_cnt), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("abort_w", 32'(w), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pair", 32'(pair_cnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_hold_done", 32'(done), 32'd0);
    #2;
    reset = 1'b0;
    idle(WIDTH + 2, 0);
    send_word(8'h03, 1'b0, -1, '0);
    idle(1, 1);

    // random words, random gaps (gap 0 loads straight from DONE)
    for (int r = 0; r < 12; r++) begin
      rd = WIDTH'($urandom);
      send_word(rd, 1'b0, -1, '0);
      idle($urandom_range(0, 2), model_pairs(rd, WIDTH));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus source for the two-state sequence detector: loads a parallel word and transmits it MSB-first, one bit per clock, on a single-bit line `w`.
- `w` is driven in the detector's input format, so the two blocks connect back-to-back.
- While shifting, the block counts "11" adjacencies in the transmitted stream. This gives the expected number of detector `z` pulses for cross-checking.
- Sits between a test/control source and the detector input.

Parameters:
- WIDTH, 8, bits per transmitted word (>=2).
- CNT_W, 4, width of `pair_cnt`; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  start request; sampled on posedge clk.
- data  input  WIDTH  word to transmit; captured when `load` is accepted.
- w  output  1  serial bit out, MSB first.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse after the last bit.
- pair_cnt  output  CNT_W  number of adjacent "11" bit pairs in the last/current word.

Behaviour:
- Reset is asynchronous and active-high. While `reset`=1:
  - state=IDLE, shift register=0, bit counter=0, prev_w=0, pair_cnt=0.
  - w=0, busy=0, done=0, taking effect immediately without a clock edge.
- States and encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - w=0, busy=0, done=0.
  - On an edge with load=1: shreg<=data, bitcnt<=0, prev_w<=0, pair_cnt<=0, state<=SHIFT.
  - load=0 stays in IDLE.
- SHIFT:
  - w = shreg[WIDTH-1] (combinational from the register); busy=1.
  - Each edge:
    - shreg shifts left with 0 fill; bitcnt+1; prev_w<=w.
    - If w=1 and prev_w=1, pair_cnt<=pair_cnt+1.
  - On the edge where bitcnt==WIDTH-1, state<=DONE.
  - Exactly WIDTH cycles are spent in SHIFT.
  - `load` is ignored in SHIFT; `data` is not re-sampled.
- DONE:
  - w=0, busy=0, done=1 for exactly one cycle. pair_cnt holds its final value.
  - With load=0 the next state is IDLE.
  - With load=1 the new word is accepted exactly as in IDLE and the next state is SHIFT. This gives back-to-back words with a single 0-bit gap cycle.
- Latency: load sampled at edge k gives the first bit (data MSB) on `w` during cycle k+1 and the last bit during cycle k+WIDTH. done=1 during cycle k+WIDTH+1.
- pair_cnt:
  - Holds its value through IDLE until the next accepted load.
  - The pair count never spans words: prev_w is cleared on load.
  - Maximum count is WIDTH-1 (all ones), so no overflow given the CNT_W rule.
- Reset asserted mid-SHIFT aborts the word. done does not pulse. After deassertion the block waits in IDLE for a new load.
- `data` changes outside the load edge have no effect.

Test Plan:
- Reset, then load data=8'b0110_1110 -> w = 0,1,1,0,1,1,1,0 on cycles 1..8 after the load edge; busy=1 for those 8 cycles; done pulse on cycle 9; pair_cnt=3.
- load data=8'hFF -> w=1 for 8 cycles; pair_cnt=7. A detector attached to `w` emits 7 z-cycles.
- load data=8'h55 -> w = 0,1,0,1,0,1,0,1; pair_cnt=0.
- Pulse load with 8'hC0 during cycle 3 of an active 8'hF0 word -> the second load is ignored. The stream stays 1,1,1,1,0,0,0,0 and pair_cnt=3.
- Hold load=1 continuously with data=8'h81 -> words repeat with one w=0 DONE gap each time; done pulses every 9 cycles; pair_cnt=0.
- Assert reset asynchronously mid-SHIFT (between edges) -> w, busy and pair_cnt go to 0 immediately and done never pulses. A later load of 8'h03 transmits cleanly with pair_cnt=1.
